// File: rtl/seg_serial_driver_pkg.sv
// Shared types and the hex glyph table for the serial seven-segment driver.
package seg_serial_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4
    } state_t;

    // All segments dark in common-anode polarity.
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    // Common-anode glyphs, bit7=a .. bit1=g, bit0=dp (dp dark).
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0:    g = 8'h03;
            4'h1:    g = 8'h9F;
            4'h2:    g = 8'h25;
            4'h3:    g = 8'h0D;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h49;
            4'h6:    g = 8'h41;
            4'h7:    g = 8'h1F;
            4'h8:    g = 8'h01;
            4'h9:    g = 8'h09;
            4'hA:    g = 8'h11;
            4'hB:    g = 8'hC1;
            4'hC:    g = 8'h63;
            4'hD:    g = 8'h85;
            4'hE:    g = 8'h61;
            default: g = 8'h71;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_serial_driver_glyph.sv
// One digit's glyph: hex lookup with decimal point, blanking, raw override and polarity.
module seg_serial_driver_glyph
    import seg_serial_driver_pkg::*;
#(
    parameter int ACTIVE_LOW_SEG = 1
) (
    input  logic [3:0] nibble,
    input  logic       dot,
    input  logic       blank,
    input  logic       raw_mode,
    input  logic [7:0] raw_byte,
    output logic [7:0] glyph
);

    logic [7:0] hex_al;

    // Hex glyph with the decimal point applied, still in common-anode polarity.
    always_comb begin
        hex_al = hex_glyph(nibble);
        if (dot) hex_al[0] = 1'b0;
    end

    // Blank wins over raw; raw bytes are already in output polarity and never inverted.
    always_comb begin
        if (blank)
            glyph = (ACTIVE_LOW_SEG != 0) ? GLYPH_BLANK : ~GLYPH_BLANK;
        else if (raw_mode)
            glyph = raw_byte;
        else
            glyph = (ACTIVE_LOW_SEG != 0) ? hex_al : ~hex_al;
    end

endmodule

// File: rtl/seg_serial_driver.sv
// N-digit seven-segment driver for a 74HC595-style chain: builds the frame,
// shifts it out on s_clk/sout and strobes EN, on refresh ticks or on demand.
module seg_serial_driver
    import seg_serial_driver_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 2,
    parameter int REFRESH        = 65536,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int MSB_FIRST      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] num,
    input  logic [NUM_DIGITS-1:0]   dot,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    raw_mode,
    input  logic [8*NUM_DIGITS-1:0] raw_seg,
    input  logic                    update,
    output logic                    s_clk,
    output logic                    s_clrn,
    output logic                    sout,
    output logic                    EN,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int FW    = 8 * NUM_DIGITS;
    localparam int BIT_W = $clog2(FW);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int REF_W = $clog2(REFRESH);

    localparam int DIV_PRE_I = (CLK_DIV >= 2) ? CLK_DIV - 2 : 0;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FW - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(DIV_PRE_I);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH - 1);

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [REF_W-1:0]  ref_cnt;
    logic              pending;
    logic [FW-1:0]     frame;
    logic [FW-1:0]     frame_ord;
    logic [FW-1:0]     shreg;
    logic              tick;
    logic              req;
    logic              div_last;
    logic              bit_last;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        seg_serial_driver_glyph #(
            .ACTIVE_LOW_SEG(ACTIVE_LOW_SEG)
        ) u_glyph (
            .nibble   (num[4*i+3:4*i]),
            .dot      (dot[i]),
            .blank    (blank[i]),
            .raw_mode (raw_mode),
            .raw_byte (raw_seg[8*i+7:8*i]),
            .glyph    (frame[8*i+7:8*i])
        );
    end

    // Reorder the frame so that index 0 is always the first bit on the wire.
    always_comb begin
        frame_ord = '0;
        for (int k = 0; k < FW; k++)
            frame_ord[k] = (MSB_FIRST != 0) ? frame[FW-1-k] : frame[k];
    end

    assign tick     = (ref_cnt == REF_LAST);
    assign req      = update | tick;
    assign div_last = (div_cnt == DIV_LAST);
    assign bit_last = (bit_cnt == BIT_LAST);

    // Free-running refresh counter; its wrap is the automatic frame request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ref_cnt <= '0;
        else if (tick)
            ref_cnt <= '0;
        else
            ref_cnt <= ref_cnt + 1'b1;
    end

    // Frame snapshot: bits still to be sent after the one currently on sout.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD)
            shreg <= frame_ord >> 1;
        else if (state == ST_SHIFT_HI && div_last && !bit_last)
            shreg <= shreg >> 1;
    end

    // Frame sequencer with registered pin outputs and the coalescing pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            pending    <= 1'b0;
            s_clk      <= 1'b0;
            s_clrn     <= 1'b0;
            sout       <= 1'b0;
            EN         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            s_clrn     <= 1'b1;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req || pending) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    pending <= req;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    s_clk   <= 1'b0;
                    sout    <= frame_ord[0];
                    state   <= ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    if (req) pending <= 1'b1;
                    if (div_last) begin
                        div_cnt <= '0;
                        s_clk   <= 1'b1;
                        state   <= ST_SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (req) pending <= 1'b1;
                    if (div_last) begin
                        div_cnt <= '0;
                        s_clk   <= 1'b0;
                        if (bit_last) begin
                            EN         <= 1'b1;
                            frame_done <= (CLK_DIV == 1);
                            state      <= ST_LATCH;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sout    <= shreg[0];
                            state   <= ST_SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (req) pending <= 1'b1;
                    if (div_last) begin
                        div_cnt <= '0;
                        EN      <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt    <= div_cnt + 1'b1;
                        frame_done <= (div_cnt == DIV_PRE);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    s_clk <= 1'b0;
                    EN    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_serial_driver.sv
// Bench for seg_serial_driver: three instances cover on-demand frames, periodic
// refresh with reversed/inverted output, and back-to-back frames via pending.
`timescale 1ns/1ps
module tb_seg_serial_driver;

    localparam int N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_a, rst_b, rst_c;
    logic [4*N-1:0] num;
    logic [N-1:0]   dot, blank;
    logic           raw_mode;
    logic [8*N-1:0] raw_seg;
    logic           upd_a, upd_off;

    logic a_sclk, a_clrn, a_sout, a_en, a_busy, a_fd;
    logic b_sclk, b_clrn, b_sout, b_en, b_busy, b_fd;
    logic c_sclk, c_clrn, c_sout, c_en, c_busy, c_fd;

    seg_serial_driver #(.NUM_DIGITS(N), .CLK_DIV(1), .REFRESH(65536),
                        .ACTIVE_LOW_SEG(1), .MSB_FIRST(0)) u_a (
        .clk(clk), .rst_n(rst_a), .num(num), .dot(dot), .blank(blank),
        .raw_mode(raw_mode), .raw_seg(raw_seg), .update(upd_a),
        .s_clk(a_sclk), .s_clrn(a_clrn), .sout(a_sout), .EN(a_en),
        .busy(a_busy), .frame_done(a_fd));

    seg_serial_driver #(.NUM_DIGITS(N), .CLK_DIV(2), .REFRESH(100),
                        .ACTIVE_LOW_SEG(0), .MSB_FIRST(1)) u_b (
        .clk(clk), .rst_n(rst_b), .num(num), .dot(dot), .blank(blank),
        .raw_mode(raw_mode), .raw_seg(raw_seg), .update(upd_off),
        .s_clk(b_sclk), .s_clrn(b_clrn), .sout(b_sout), .EN(b_en),
        .busy(b_busy), .frame_done(b_fd));

    seg_serial_driver #(.NUM_DIGITS(N), .CLK_DIV(1), .REFRESH(10),
                        .ACTIVE_LOW_SEG(1), .MSB_FIRST(0)) u_c (
        .clk(clk), .rst_n(rst_c), .num(num), .dot(dot), .blank(blank),
        .raw_mode(raw_mode), .raw_seg(raw_seg), .update(upd_off),
        .s_clk(c_sclk), .s_clrn(c_clrn), .sout(c_sout), .EN(c_en),
        .busy(c_busy), .frame_done(c_fd));

    int n_tests = 0;
    int n_fail  = 0;
    int tcount  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle, landing just after the falling edge so monitors have already run.
    task automatic step();
        @(negedge clk);
        #1;
        tcount++;
    endtask

    // Instance A monitor: LSB-first capture, scoreboard compare at each EN rise.
    logic [15:0] a_exp_q[$];
    logic [15:0] a_shift = '0;
    int          a_nbits = 0;
    int          a_frames = 0;
    logic        a_sclk_q = 1'b0, a_en_q = 1'b0;
    always @(negedge clk) begin
        if (!rst_a) begin
            a_nbits = 0;
        end else begin
            if (a_sclk && !a_sclk_q) begin
                a_shift = {a_sout, a_shift[15:1]};
                a_nbits++;
            end
            if (a_en && !a_en_q) begin
                a_frames++;
                chk("a_nbits", a_nbits, 16);
                chk("a_exp_avail", a_exp_q.size() > 0, 1);
                if (a_exp_q.size() > 0)
                    chk("a_frame", {16'h0, a_shift}, {16'h0, a_exp_q.pop_front()});
                a_nbits = 0;
            end
        end
        a_sclk_q = a_sclk;
        a_en_q   = a_en;
    end

    // Instance B monitor: MSB-first capture into b_shift.
    logic [15:0] b_shift = '0;
    int          b_nbits = 0;
    int          b_frames = 0;
    logic        b_sclk_q = 1'b0, b_en_q = 1'b0;
    always @(negedge clk) begin
        if (!rst_b) begin
            b_nbits = 0;
        end else begin
            if (b_sclk && !b_sclk_q) begin
                b_shift = {b_shift[14:0], b_sout};
                b_nbits++;
            end
            if (b_en && !b_en_q) begin
                b_frames++;
                chk("b_nbits", b_nbits, 16);
                b_nbits = 0;
            end
        end
        b_sclk_q = b_sclk;
        b_en_q   = b_en;
    end

    task automatic a_run(input logic [15:0] exp);
        int f0;
        f0 = a_frames;
        a_exp_q.push_back(exp);
        upd_a = 1'b1; step(); upd_a = 1'b0;
        for (int i = 0; i < 100 && a_frames == f0; i++) step();
        chk("a_frame_count", a_frames, f0 + 1);
        step();
    endtask

    task automatic b_wait_frame(output int t);
        int f0;
        f0 = b_frames;
        for (int i = 0; i < 250 && b_frames == f0; i++) step();
        chk("b_frame_count", b_frames, f0 + 1);
        t = tcount;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, t1, t2, act, run;
        int k_busy, k_rise, k_en, k_fd, k_idle, n_fd;

        rst_a = 0; rst_b = 0; rst_c = 0;
        num = '0; dot = '0; blank = '0; raw_mode = 0; raw_seg = '0;
        upd_a = 0; upd_off = 0;
        repeat (3) step();

        // reset values
        chk("rst_sclk", a_sclk, 0);
        chk("rst_clrn", a_clrn, 0);
        chk("rst_sout", a_sout, 0);
        chk("rst_en",   a_en,   0);
        chk("rst_busy", a_busy, 0);
        chk("rst_fd",   a_fd,   0);
        rst_a = 1; rst_b = 1; rst_c = 1;
        step();
        chk("clrn_rise", a_clrn, 1);
        act = 0;
        repeat (20) begin
            step();
            act = act | a_busy | a_sclk | a_en;
        end
        chk("idle_quiet", act, 0);

        // first frame timing, num=10 -> 9F03
        num = 8'h10;
        a_exp_q.push_back(16'h9F03);
        upd_a = 1; step(); upd_a = 0;
        k_busy = -1; k_rise = -1; k_en = -1; k_fd = -1; k_idle = -1; n_fd = 0;
        for (int k = 1; k <= 45; k++) begin
            if (k > 1) step();
            if (a_busy && k_busy < 0) k_busy = k;
            if (a_sclk && k_rise < 0) k_rise = k;
            if (a_en && k_en < 0) k_en = k;
            if (a_fd && k_fd < 0) k_fd = k;
            if (a_fd) n_fd++;
            if (!a_busy && k_busy > 0 && k_idle < 0) k_idle = k;
        end
        chk("lat_busy", k_busy, 1);
        chk("lat_first_rise", k_rise, 3);
        chk("lat_en", k_en, 34);
        chk("lat_frame_done", k_fd, 34);
        chk("frame_done_width", n_fd, 1);
        chk("lat_idle", k_idle, 35);

        // dot / blank / raw glyph rules
        dot = 2'b01; blank = 2'b10;
        a_run(16'hFF02);
        raw_mode = 1; raw_seg = 16'hA55A; blank = 2'b00;
        a_run(16'hA55A);
        blank = 2'b01;
        a_run(16'hA5FF);
        raw_mode = 0; blank = 2'b00; dot = 2'b10; num = 8'hF8;
        a_run(16'h7001);
        dot = 2'b00; num = 8'hE5;
        a_run(16'h6149);

        // mid-frame changes and coalesced requests
        num = 8'h10;
        f0 = a_frames;
        a_exp_q.push_back(16'h9F03);
        upd_a = 1; step(); upd_a = 0;
        repeat (5) step();
        num = 8'h32;
        upd_a = 1; step(); upd_a = 0;
        repeat (3) step();
        upd_a = 1; step(); upd_a = 0;
        a_exp_q.push_back(16'h0D25);
        for (int i = 0; i < 60 && !a_fd; i++) step();
        chk("coal_fd_seen", a_fd, 1);
        step();
        chk("coal_gap_idle", a_busy, 0);
        step();
        chk("coal_pending_load", a_busy, 1);
        for (int i = 0; i < 60 && a_frames != f0 + 2; i++) step();
        chk("coal_two_frames", a_frames, f0 + 2);
        repeat (60) step();
        chk("coal_no_extra", a_frames, f0 + 2);
        chk("coal_queue_empty", a_exp_q.size(), 0);

        // abort mid SHIFT_HI on instance A
        num = 8'h10;
        a_exp_q.push_back(16'h9F03);
        upd_a = 1; step(); upd_a = 0;
        for (int i = 0; i < 40 && !(a_sclk && a_nbits == 5); i++) step();
        chk("abort_reached", a_nbits, 5);
        f0 = a_frames;
        rst_a = 0;
        #1;
        chk("abort_sclk", a_sclk, 0);
        chk("abort_clrn", a_clrn, 0);
        chk("abort_sout", a_sout, 0);
        chk("abort_en",   a_en,   0);
        chk("abort_busy", a_busy, 0);
        a_exp_q.delete();
        step(); step();
        rst_a = 1;
        repeat (40) step();
        chk("abort_no_en", a_frames, f0);
        a_run(16'h9F03);

        // instance B: refresh period, reversed bit order, inverted glyphs
        num = 8'hA7; dot = 2'b10; blank = 2'b00; raw_mode = 0;
        b_wait_frame(t1);
        b_wait_frame(t2);
        chk("b_frame_hex", {16'h0, b_shift}, 32'h0000EFE0);
        b_wait_frame(t1);
        chk("b_refresh_period", t1 - t2, 100);
        blank = 2'b01;
        b_wait_frame(t1);
        b_wait_frame(t1);
        chk("b_frame_blank", {16'h0, b_shift}, 32'h0000EF00);
        blank = 2'b00; raw_mode = 1; raw_seg = 16'h3C5A;
        b_wait_frame(t1);
        b_wait_frame(t1);
        chk("b_frame_raw", {16'h0, b_shift}, 32'h00003C5A);

        // abort mid SHIFT_HI on instance B
        for (int i = 0; i < 150 && !(b_sclk && b_nbits == 3); i++) step();
        chk("b_abort_reached", b_nbits, 3);
        f0 = b_frames;
        rst_b = 0;
        #1;
        chk("b_abort_sclk", b_sclk, 0);
        chk("b_abort_clrn", b_clrn, 0);
        chk("b_abort_en",   b_en,   0);
        chk("b_abort_busy", b_busy, 0);
        step(); step();
        rst_b = 1;
        b_wait_frame(t1);
        chk("b_after_abort_frames", b_frames, f0 + 1);
        chk("b_after_abort_data", {16'h0, b_shift}, 32'h00003C5A);

        // instance C: back-to-back frames through pending, one idle cycle between
        for (int i = 0; i < 60 && c_busy; i++) step();
        chk("c_first_fall", c_busy, 0);
        for (int f = 0; f < 3; f++) begin
            run = 0;
            for (int i = 0; i < 20 && !c_busy; i++) begin run++; step(); end
            chk("c_idle_gap", run, 1);
            run = 0;
            for (int i = 0; i < 60 && c_busy; i++) begin run++; step(); end
            chk("c_frame_len", run, 34);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
